// File: rtl/memory_controller.sv
// Command-driven initiator for the 16x8 register-file memory: write, dual read, pair scan, clear.
// Optional scan checksum outputs when MEMCTRL_SCAN_CHECKSUM_EN is defined.
module memory_controller #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmdValid,
   output logic                  cmdReady,
   input  logic [1:0]            cmdOp,
   input  logic [ADDR_WIDTH-1:0] cmdAddress1,
   input  logic [ADDR_WIDTH-1:0] cmdAddress2,
   input  logic [DATA_WIDTH-1:0] cmdData,
   output logic                  memWriteEnable,
   output logic [ADDR_WIDTH-1:0] memWriteAddress,
   output logic [DATA_WIDTH-1:0] memWriteData,
   output logic [ADDR_WIDTH-1:0] memReadAddress1,
   output logic [ADDR_WIDTH-1:0] memReadAddress2,
   input  logic [DATA_WIDTH-1:0] memReadData1,
   input  logic [DATA_WIDTH-1:0] memReadData2,
`ifdef MEMCTRL_SCAN_CHECKSUM_EN
   output logic [DATA_WIDTH-1:0] scanSum,
   output logic                  scanSumValid,
`endif
   output logic                  respValid,
   input  logic                  respReady,
   output logic [ADDR_WIDTH-1:0] respAddress,
   output logic [DATA_WIDTH-1:0] respData1,
   output logic [DATA_WIDTH-1:0] respData2
);

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_SCAN  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef enum logic [2:0] {IDLE, WRITE, READ, SCAN, CLEAR, RESP} state_t;

   state_t                state;
   state_t                nextState;
   logic [ADDR_WIDTH-1:0] cnt;
   logic [1:0]            opReg;
   logic [ADDR_WIDTH-1:0] addr1Reg;
   logic [ADDR_WIDTH-1:0] addr2Reg;
   logic [DATA_WIDTH-1:0] dataReg;
   logic [ADDR_WIDTH-1:0] rdHold1;
   logic [ADDR_WIDTH-1:0] rdHold2;
   logic                  respFire;
   logic                  scanLast;
   logic [ADDR_WIDTH-2:0] pairIdx;

   assign pairIdx  = cnt[ADDR_WIDTH-2:0];
   assign scanLast = (pairIdx == '1);
   assign cmdReady = (state == IDLE);
   assign respValid = (state == RESP);
   assign respFire = respValid && respReady;

   always_comb begin
      nextState = state;
      unique case (state)
         IDLE: begin
            if (cmdValid) begin
               unique case (cmdOp)
                  OP_WRITE: nextState = WRITE;
                  OP_READ:  nextState = READ;
                  OP_SCAN:  nextState = SCAN;
                  OP_CLEAR: nextState = CLEAR;
                  default:  nextState = IDLE;
               endcase
            end
         end
         WRITE: nextState = IDLE;
         READ:  nextState = RESP;
         SCAN:  nextState = RESP;
         CLEAR: if (cnt == '1) nextState = IDLE;
         RESP: begin
            if (respReady) begin
               if (opReg == OP_SCAN && !scanLast) nextState = SCAN;
               else nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Read addresses hold their last value whenever no read is in progress
   always_comb begin
      memWriteEnable  = 1'b0;
      memWriteAddress = '0;
      memWriteData    = '0;
      memReadAddress1 = rdHold1;
      memReadAddress2 = rdHold2;
      unique case (state)
         WRITE: begin
            memWriteEnable  = 1'b1;
            memWriteAddress = addr1Reg;
            memWriteData    = dataReg;
         end
         CLEAR: begin
            memWriteEnable  = 1'b1;
            memWriteAddress = cnt;
            memWriteData    = CLEAR_VALUE;
         end
         READ: begin
            memReadAddress1 = addr1Reg;
            memReadAddress2 = addr2Reg;
         end
         SCAN: begin
            memReadAddress1 = {pairIdx, 1'b0};
            memReadAddress2 = {pairIdx, 1'b1};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         opReg       <= '0;
         addr1Reg    <= '0;
         addr2Reg    <= '0;
         dataReg     <= '0;
         rdHold1     <= '0;
         rdHold2     <= '0;
         respAddress <= '0;
         respData1   <= '0;
         respData2   <= '0;
      end else begin
         state <= nextState;
         if (cmdValid && cmdReady) begin
            opReg    <= cmdOp;
            addr1Reg <= cmdAddress1;
            addr2Reg <= cmdAddress2;
            dataReg  <= cmdData;
         end
         if (state == READ || state == SCAN) begin
            rdHold1     <= memReadAddress1;
            rdHold2     <= memReadAddress2;
            respAddress <= memReadAddress1;
            respData1   <= memReadData1;
            respData2   <= memReadData2;
         end
         if (state == CLEAR) cnt <= cnt + 1'b1;
         if (respFire && opReg == OP_SCAN) begin
            if (scanLast) cnt <= '0;
            else cnt <= cnt + 1'b1;
         end
      end
   end

`ifdef MEMCTRL_SCAN_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         scanSum      <= '0;
         scanSumValid <= 1'b0;
      end else begin
         scanSumValid <= respFire && opReg == OP_SCAN && scanLast;
         if (cmdValid && cmdReady && cmdOp == OP_SCAN) scanSum <= '0;
         else if (state == SCAN)
            scanSum <= scanSum + memReadData1 + memReadData2;
      end
   end
`endif

endmodule

// File: tb/tb_memory_controller.sv
// Scoreboard bench for memory_controller with a behavioural 16x8 register file.
// Checksum scenario compiled in when MEMCTRL_SCAN_CHECKSUM_EN is defined.
module tb_memory_controller;

   typedef struct packed {
      logic [3:0] a;
      logic [7:0] d1;
      logic [7:0] d2;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmdValid = 1'b0;
   logic       cmdReady;
   logic [1:0] cmdOp = 2'b00;
   logic [3:0] cmdAddress1 = '0;
   logic [3:0] cmdAddress2 = '0;
   logic [7:0] cmdData = '0;
   logic       memWriteEnable;
   logic [3:0] memWriteAddress;
   logic [7:0] memWriteData;
   logic [3:0] memReadAddress1;
   logic [3:0] memReadAddress2;
   logic [7:0] memReadData1;
   logic [7:0] memReadData2;
   logic       respValid;
   logic       respReady = 1'b0;
   logic [3:0] respAddress;
   logic [7:0] respData1;
   logic [7:0] respData2;
`ifdef MEMCTRL_SCAN_CHECKSUM_EN
   logic [7:0] scanSum;
   logic       scanSumValid;
   int         pulses = 0;
   logic [7:0] lastSum = '0;
`endif

   logic [7:0] mem [16] = '{default: 8'hEE};
   exp_t       sbq [$];
   int         compared = 0;
   int         mismatched = 0;

   memory_controller dut (
      .clk(clk), .reset(reset),
      .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp),
      .cmdAddress1(cmdAddress1), .cmdAddress2(cmdAddress2), .cmdData(cmdData),
      .memWriteEnable(memWriteEnable), .memWriteAddress(memWriteAddress),
      .memWriteData(memWriteData),
      .memReadAddress1(memReadAddress1), .memReadAddress2(memReadAddress2),
      .memReadData1(memReadData1), .memReadData2(memReadData2),
`ifdef MEMCTRL_SCAN_CHECKSUM_EN
      .scanSum(scanSum), .scanSumValid(scanSumValid),
`endif
      .respValid(respValid), .respReady(respReady), .respAddress(respAddress),
      .respData1(respData1), .respData2(respData2)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (memWriteEnable) mem[memWriteAddress] <= memWriteData;

   assign memReadData1 = mem[memReadAddress1];
   assign memReadData2 = mem[memReadAddress2];

`ifdef MEMCTRL_SCAN_CHECKSUM_EN
   always @(negedge clk)
      if (scanSumValid) begin
         pulses++;
         lastSum = scanSum;
      end
`endif

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [3:0] a1,
                        input logic [3:0] a2, input logic [7:0] d);
      int n = 0;
      cmdValid = 1'b1;
      cmdOp = op;
      cmdAddress1 = a1;
      cmdAddress2 = a2;
      cmdData = d;
      while (!cmdReady && n < 50) begin
         tick();
         n++;
      end
      compared++;
      if (cmdReady !== 1'b1) begin
         mismatched++;
         $display("FAIL issue_ready: cmdReady=%b want 1", cmdReady);
      end
      tick();
      cmdValid = 1'b0;
   endtask

   task automatic collect(input string nm);
      exp_t e;
      int n;
      respReady = 1'b1;
      while (sbq.size() > 0) begin
         n = 0;
         while (!respValid && n < 40) begin
            tick();
            n++;
         end
         e = sbq.pop_front();
         compared++;
         if (respValid !== 1'b1 || respAddress !== e.a ||
             respData1 !== e.d1 || respData2 !== e.d2) begin
            mismatched++;
            $display("FAIL %s resp: got v=%b a=%h d1=%h d2=%h want a=%h d1=%h d2=%h",
                     nm, respValid, respAddress, respData1, respData2, e.a, e.d1, e.d2);
         end
         if (respValid !== 1'b1) sbq.delete();
         else tick();
      end
      respReady = 1'b0;
   endtask

   task automatic write_all(input logic [7:0] base, input logic step);
      for (int i = 0; i < 16; i++)
         issue(2'b00, 4'(i), 4'd0, step ? base + 8'(i) : base);
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      compared++;
      if (cmdReady !== 1'b1 || respValid !== 1'b0 || memWriteEnable !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_ctrl: rdy=%b rv=%b we=%b want 1 0 0",
                  cmdReady, respValid, memWriteEnable);
      end
      compared++;
      if (respAddress !== 4'h0 || respData1 !== 8'h0 || respData2 !== 8'h0 ||
          memReadAddress1 !== 4'h0 || memReadAddress2 !== 4'h0 ||
          memWriteAddress !== 4'h0 || memWriteData !== 8'h0) begin
         mismatched++;
         $display("FAIL reset_data: ra=%h d1=%h d2=%h rd1=%h rd2=%h wa=%h wd=%h want all 0",
                  respAddress, respData1, respData2, memReadAddress1,
                  memReadAddress2, memWriteAddress, memWriteData);
      end
   endtask

   task automatic test_clear();
      issue(2'b11, 4'd0, 4'd0, 8'd0);
      for (int i = 0; i < 16; i++) begin
         compared++;
         if (memWriteEnable !== 1'b1 || memWriteAddress !== 4'(i) ||
             memWriteData !== 8'h00 || cmdReady !== 1'b0) begin
            mismatched++;
            $display("FAIL clear_cycle%0d: we=%b wa=%h wd=%h rdy=%b want 1 %h 00 0",
                     i, memWriteEnable, memWriteAddress, memWriteData, cmdReady, 4'(i));
         end
         tick();
      end
      compared++;
      if (memWriteEnable !== 1'b0 || cmdReady !== 1'b1) begin
         mismatched++;
         $display("FAIL clear_done: we=%b rdy=%b want 0 1", memWriteEnable, cmdReady);
      end
      for (int i = 0; i < 16; i++) begin
         compared++;
         if (mem[i] !== 8'h00) begin
            mismatched++;
            $display("FAIL clear_mem%0d: got %h want 00", i, mem[i]);
         end
      end
   endtask

   task automatic test_write_read();
      issue(2'b00, 4'd3, 4'd0, 8'hA5);
      compared++;
      if (memWriteEnable !== 1'b1 || memWriteAddress !== 4'd3 || memWriteData !== 8'hA5) begin
         mismatched++;
         $display("FAIL write_port: we=%b wa=%h wd=%h want 1 3 a5",
                  memWriteEnable, memWriteAddress, memWriteData);
      end
      sbq.push_back('{a: 4'd3, d1: 8'hA5, d2: 8'h00});
      issue(2'b01, 4'd3, 4'd0, 8'h00);
      compared++;
      if (respValid !== 1'b0 || memReadAddress1 !== 4'd3 || memReadAddress2 !== 4'd0 ||
          memWriteEnable !== 1'b0) begin
         mismatched++;
         $display("FAIL read_cycle: rv=%b rd1=%h rd2=%h we=%b want 0 3 0 0",
                  respValid, memReadAddress1, memReadAddress2, memWriteEnable);
      end
      tick();
      compared++;
      if (respValid !== 1'b1) begin
         mismatched++;
         $display("FAIL read_latency1: rv=%b want 1", respValid);
      end
      tick();
      compared++;
      if (respValid !== 1'b1) begin
         mismatched++;
         $display("FAIL read_latency2: rv=%b want 1", respValid);
      end
      collect("write_read");
      compared++;
      if (respValid !== 1'b0 || cmdReady !== 1'b1) begin
         mismatched++;
         $display("FAIL read_done: rv=%b rdy=%b want 0 1", respValid, cmdReady);
      end
   endtask

   task automatic test_scan();
      write_all(8'h10, 1'b1);
      for (int k = 0; k < 8; k++)
         sbq.push_back('{a: 4'(2 * k), d1: 8'h10 + 8'(2 * k), d2: 8'h11 + 8'(2 * k)});
      respReady = 1'b1;
      issue(2'b10, 4'd0, 4'd0, 8'd0);
      collect("scan");
      tick();
      compared++;
      if (respValid !== 1'b0 || cmdReady !== 1'b1) begin
         mismatched++;
         $display("FAIL scan_done: rv=%b rdy=%b want 0 1", respValid, cmdReady);
      end
   endtask

   task automatic test_stall();
      sbq.push_back('{a: 4'd5, d1: 8'h15, d2: 8'h16});
      issue(2'b01, 4'd5, 4'd6, 8'd0);
      tick();
      cmdValid = 1'b1;
      cmdOp = 2'b00;
      cmdAddress1 = 4'd0;
      cmdData = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         compared++;
         if (respValid !== 1'b1 || respAddress !== 4'd5 || respData1 !== 8'h15 ||
             respData2 !== 8'h16 || cmdReady !== 1'b0 || memWriteEnable !== 1'b0) begin
            mismatched++;
            $display("FAIL stall%0d: rv=%b a=%h d1=%h d2=%h rdy=%b we=%b want 1 5 15 16 0 0",
                     i, respValid, respAddress, respData1, respData2, cmdReady, memWriteEnable);
         end
         tick();
      end
      cmdValid = 1'b0;
      collect("stall");
      tick();
      compared++;
      if (mem[0] !== 8'h10) begin
         mismatched++;
         $display("FAIL stall_ignored_cmd: mem0=%h want 10", mem[0]);
      end
   endtask

   task automatic test_reset_mid_clear();
      issue(2'b11, 4'd0, 4'd0, 8'd0);
      for (int i = 0; i < 5; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      compared++;
      if (cmdReady !== 1'b1 || respValid !== 1'b0 || memWriteEnable !== 1'b0) begin
         mismatched++;
         $display("FAIL midclear_ctrl: rdy=%b rv=%b we=%b want 1 0 0",
                  cmdReady, respValid, memWriteEnable);
      end
      tick();
      for (int i = 0; i < 16; i++) begin
         logic [7:0] want;
         want = (i < 6) ? 8'h00 : 8'h10 + 8'(i);
         compared++;
         if (mem[i] !== want) begin
            mismatched++;
            $display("FAIL midclear_mem%0d: got %h want %h", i, mem[i], want);
         end
      end
   endtask

`ifdef MEMCTRL_SCAN_CHECKSUM_EN
   task automatic test_checksum();
      write_all(8'h20, 1'b0);
      for (int k = 0; k < 8; k++)
         sbq.push_back('{a: 4'(2 * k), d1: 8'h20, d2: 8'h20});
      pulses = 0;
      respReady = 1'b1;
      issue(2'b10, 4'd0, 4'd0, 8'd0);
      collect("checksum_scan");
      for (int i = 0; i < 4; i++) tick();
      compared++;
      if (pulses !== 1 || lastSum !== 8'h00) begin
         mismatched++;
         $display("FAIL checksum: pulses=%0d sum=%h want 1 00", pulses, lastSum);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_clear();
      test_write_read();
      test_scan();
      test_stall();
      test_reset_mid_clear();
`ifdef MEMCTRL_SCAN_CHECKSUM_EN
      test_checksum();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
